// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared defaults, fill-state enum and weight index helpers
package tpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ROWS   = 2;
    localparam int DEF_COLS   = 2;

    // Shadow-bank fill progress
    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_FILLING = 2'd1,
        FILL_FULL    = 2'd2
    } fill_state_e;

    // Row-major weight index: index = r*cols + c
    function automatic int unsigned idx(input int unsigned r,
                                        input int unsigned c,
                                        input int unsigned cols = DEF_COLS);
        return r * cols + c;
    endfunction

    // Index width for n entries, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/weight_pingpong_buffer_if.sv
// rtl/weight_pingpong_buffer_if.sv - host load / controller swap / weight output bundle
//
// master : host + array controller side (drives load_* and swap_req)
// slave  : weight_pingpong_buffer side (drives ready/idx/ack/weights/status)
interface weight_pingpong_buffer_if
    import tpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = clog2_min1(N);

    logic                  load_start;
    logic                  load_valid;
    logic [DATA_W-1:0]     load_data;
    logic                  load_ready;
    logic [IDX_W-1:0]      load_idx;
    logic                  swap_req;
    logic                  swap_ack;
    logic [N*DATA_W-1:0]   weights;
    logic                  weights_valid;
    logic                  overflow_err;

    modport master (
        output load_start, load_valid, load_data, swap_req,
        input  load_ready, load_idx, swap_ack, weights, weights_valid, overflow_err
    );

    modport slave (
        input  load_start, load_valid, load_data, swap_req,
        output load_ready, load_idx, swap_ack, weights, weights_valid, overflow_err
    );

endinterface

// File: rtl/weight_bank.sv
// rtl/weight_bank.sv - N x DATA_W weight register file, one write port, flattened read
//
// clk, rst_n : clock, async active-low reset (clears all entries)
// we         : write enable
// waddr      : entry to write
// wdata      : value to write
// rdata      : all entries, entry k at [k*DATA_W +: DATA_W]
module weight_bank #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int IDX_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [N*DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [N];
    logic [DATA_W-1:0] mem_d [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            mem_d[k] = mem_q[k];
        end
        // Guard keeps non-power-of-two N from writing past the last entry
        if (we && (int'(waddr) < N)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < N; k++) begin
            rdata[k*DATA_W +: DATA_W] = mem_q[k];
        end
    end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// rtl/weight_pingpong_buffer.sv - double-buffered systolic weight store
//
// clk, rst_n : clock, async active-low reset
// bus        : slave side of weight_pingpong_buffer_if
//   load_start/load_valid/load_data in, load_ready/load_idx out : shadow fill
//   swap_req in, swap_ack out : bank swap handshake (ack valid in the cycle
//                               whose closing edge performs the swap)
//   weights/weights_valid out : active bank contents and commit status
//   overflow_err out          : sticky, write attempted while shadow full
module weight_pingpong_buffer
    import tpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    weight_pingpong_buffer_if.slave bus
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = clog2_min1(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    fill_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bank_sel_q, bank_sel_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    fill_state_e      eff_state;
    logic [IDX_W-1:0] eff_idx;
    logic             load_ready;
    logic             swap_go;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             we0, we1;
    logic [N*DATA_W-1:0] rd0, rd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bank_sel_d = bank_sel_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        wr_en      = 1'b0;
        wr_idx     = idx_q;

        load_ready = (state_q != FILL_FULL);
        swap_go    = (state_q == FILL_FULL) && bus.swap_req && !bus.load_start;

        // load_start restarts the fill before this cycle's write is considered,
        // so a coincident byte lands at index 0
        eff_state  = bus.load_start ? FILL_EMPTY : state_q;
        eff_idx    = bus.load_start ? '0 : idx_q;

        if (bus.load_valid && !load_ready) begin
            ovf_d = 1'b1;
        end

        if (bus.load_start) begin
            state_d = FILL_EMPTY;
            idx_d   = '0;
        end

        if (bus.load_valid && (eff_state != FILL_FULL)) begin
            wr_en  = 1'b1;
            wr_idx = eff_idx;
            if (eff_idx == LAST_IDX) begin
                idx_d   = '0;
                state_d = FILL_FULL;
            end else begin
                idx_d   = eff_idx + IDX_W'(1);
                state_d = FILL_FILLING;
            end
        end else if (swap_go) begin
            // Only reachable from FULL, where writes are blocked, so the
            // bank being swapped in is never written in the same cycle
            bank_sel_d = ~bank_sel_q;
            valid_d    = 1'b1;
            state_d    = FILL_EMPTY;
            idx_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL_EMPTY;
            idx_q      <= '0;
            bank_sel_q <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bank_sel_q <= bank_sel_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // bank_sel names the active bank; writes always go to the other one
    assign we0 = wr_en &&  bank_sel_q;
    assign we1 = wr_en && !bank_sel_q;

    weight_bank #(.DATA_W(DATA_W), .N(N), .IDX_W(IDX_W)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we0),
        .waddr (wr_idx),
        .wdata (bus.load_data),
        .rdata (rd0)
    );

    weight_bank #(.DATA_W(DATA_W), .N(N), .IDX_W(IDX_W)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we1),
        .waddr (wr_idx),
        .wdata (bus.load_data),
        .rdata (rd1)
    );

    // Mux selected by a flop over register outputs only: no path from load_*
    assign bus.weights       = bank_sel_q ? rd1 : rd0;
    assign bus.weights_valid = valid_q;
    assign bus.load_ready    = load_ready;
    assign bus.load_idx      = idx_q;
    assign bus.swap_ack      = swap_go;
    assign bus.overflow_err  = ovf_q;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// tb/tb_weight_pingpong_buffer.sv - scoreboard bench for weight_pingpong_buffer
module tb_weight_pingpong_buffer;
    import tpu_pkg::*;

    localparam int DW = 8;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int N  = R * C;

    logic clk;
    logic rst_n;

    weight_pingpong_buffer_if #(.DATA_W(DW), .ROWS(R), .COLS(C)) bus ();

    weight_pingpong_buffer #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes collected into the shadow set since the last
    // start/swap, plus committed status
    logic [DW-1:0]     m_q[$];
    logic              m_ov;
    logic              m_valid;
    logic [N*DW-1:0]   exp_q[$];

    logic [N*DW-1:0]   cur_w;
    logic [N*DW-1:0]   pend_w;
    bit                pending;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] pack_set(input logic [DW-1:0] q[$]);
        logic [N*DW-1:0] v;
        v = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                v[idx(r, c, C)*DW +: DW] = q[idx(r, c, C)];
            end
        end
        return v;
    endfunction

    // Drive one cycle of inputs (called at posedge+1), predict its effect,
    // and commit the prediction just after the edge that applies it
    task automatic step(input bit ls, input bit lv, input logic [DW-1:0] d, input bit sr);
        logic [DW-1:0] nq[$];
        bit            nov;
        bit            full;
        bit            sw;
        bus.load_start = ls;
        bus.load_valid = lv;
        bus.load_data  = d;
        bus.swap_req   = sr;
        nq   = m_q;
        nov  = m_ov;
        sw   = 1'b0;
        full = (m_q.size() == N);
        if (lv && full) nov = 1'b1;
        if (ls) begin
            nq.delete();
            if (lv) nq.push_back(d);
        end else if (full) begin
            if (sr) begin
                sw = 1'b1;
                exp_q.push_back(pack_set(m_q));
                nq.delete();
            end
        end else if (lv) begin
            nq.push_back(d);
        end
        @(posedge clk);
        #1;
        m_q  = nq;
        m_ov = nov;
        if (sw) m_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic load4(input logic [31:0] v);
        logic [31:0] t;
        t = v;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, t[k*8 +: 8], 1'b0);
    endtask

    // Monitor: compares DUT outputs against the model away from the edge
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
            cur_w   = '0;
        end else begin
            if (pending) begin
                chk("weights_after_swap", 64'(bus.weights), 64'(pend_w));
                cur_w   = pend_w;
                pending = 1'b0;
            end else begin
                chk("weights_stable", 64'(bus.weights), 64'(cur_w));
            end
            chk("weights_valid", 64'(bus.weights_valid), 64'(m_valid));
            chk("load_ready", 64'(bus.load_ready), 64'(m_q.size() != N));
            chk("load_idx", 64'(bus.load_idx), 64'(m_q.size() % N));
            chk("overflow_err", 64'(bus.overflow_err), 64'(m_ov));
            chk("swap_ack", 64'(bus.swap_ack), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                pend_w  = exp_q.pop_front();
                pending = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.swap_req   = 1'b0;
        m_ov           = 1'b0;
        m_valid        = 1'b0;
        pending        = 1'b0;
        cur_w          = '0;

        #22;
        chk("reset_weights", 64'(bus.weights), 64'h0);
        chk("reset_valid", 64'(bus.weights_valid), 64'h0);
        chk("reset_ready", 64'(bus.load_ready), 64'h1);
        chk("reset_idx", 64'(bus.load_idx), 64'h0);
        chk("reset_ack", 64'(bus.swap_ack), 64'h0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        idle(3);
        load4(32'h44332211);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(2);
        chk("first_set", 64'(bus.weights), 64'h44332211);

        load4(32'h44332211);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        idle(2);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(2);
        chk("overflow_sticky", 64'(bus.overflow_err), 64'h1);
        chk("overflow_ignored", 64'(bus.weights), 64'h44332211);

        load4(32'hA4A3A2A1);
        idle(3);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(1);
        chk("second_set", 64'(bus.weights), 64'hA4A3A2A1);

        step(1'b0, 1'b1, 8'hE1, 1'b0);
        step(1'b0, 1'b1, 8'hE2, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        load4(32'h04030201);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(1);
        chk("restart_set", 64'(bus.weights), 64'h04030201);

        // Swap request coincident with the final write must not be taken
        step(1'b0, 1'b1, 8'h71, 1'b1);
        step(1'b0, 1'b1, 8'h72, 1'b1);
        step(1'b0, 1'b1, 8'h73, 1'b1);
        step(1'b0, 1'b1, 8'h74, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(1);
        chk("final_write_swap", 64'(bus.weights), 64'h74737271);

        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 DW'($urandom), ($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset mid-fill, off the clock edge
        load4(32'hDEADBEEF);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 8'h99, 1'b0);
        #3;
        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.swap_req   = 1'b0;
        #1;
        chk("async_weights", 64'(bus.weights), 64'h0);
        chk("async_valid", 64'(bus.weights_valid), 64'h0);
        chk("async_idx", 64'(bus.load_idx), 64'h0);
        chk("async_ready", 64'(bus.load_ready), 64'h1);
        chk("async_ovf", 64'(bus.overflow_err), 64'h0);
        m_q.delete();
        exp_q.delete();
        m_ov    = 1'b0;
        m_valid = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 DW'($urandom), ($urandom_range(0, 2) == 0));
        end
        idle(4);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
